// File: rtl/alu_bus_controller.sv
// Command sequencer for the 16-bit ALU: reads operands from a local register file,
// drives the ALU for a settle time, samples its bus, writes back and returns the result.
module alu_bus_controller #(
  parameter int WIDTH  = 16,
  parameter int REGS   = 8,
  parameter int ADDR_W = 3,
  parameter int SETTLE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_srca,
  input  logic [ADDR_W-1:0] cmd_srcb,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_op,
  input  logic [WIDTH-1:0]  alu_bus,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [ADDR_W-1:0] res_dst,
  output logic              res_zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_NOT  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_MOVE = 2'b11;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [ADDR_W-1:0]  r_dst;
  logic [WIDTH-1:0]   r_imm;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic               r_alu_op;
  logic [WIDTH-1:0]   r_res_data;
  logic [ADDR_W-1:0]  r_res_dst;
  logic               r_res_zero;
  logic [WIDTH-1:0]   r_rf [REGS];

  logic               w_cmd_ready;
  logic               w_res_valid;
  logic               w_accept;
  logic               w_write;
  logic [WIDTH-1:0]   w_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_res_valid  = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = (cmd_op == OP_LOAD) ? S_WRITE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_write      = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = w_cmd_ready && cmd_valid;
  assign w_wdata  = (r_op == OP_LOAD) ? r_imm : alu_bus;

  // LOAD never touches the ALU, so its operand registers keep their previous values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_dst      <= '0;
      r_imm      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= 1'b0;
      r_res_data <= '0;
      r_res_dst  <= '0;
      r_res_zero <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_dst <= cmd_dst;
        r_imm <= cmd_imm;
        r_cnt <= CNT_INIT;
        if (cmd_op != OP_LOAD) begin
          r_alu_a  <= r_rf[cmd_srca];
          r_alu_b  <= (cmd_op == OP_MOVE) ? '0 : r_rf[cmd_srcb];
          r_alu_op <= (cmd_op != OP_NOT);
        end
      end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_write) begin
        r_res_data <= w_wdata;
        r_res_dst  <= r_dst;
        r_res_zero <= (w_wdata == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_write) begin
      r_rf[r_dst] <= w_wdata;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign res_valid = w_res_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign res_dst   = r_res_dst;
  assign res_zero  = r_res_zero;
  assign dbg_data  = r_rf[dbg_addr];

endmodule
